// File: rtl/ntt_bist_ctrl_if.sv
// ROM read port and NTT core stream port seen from the BIST controller.
// Controller drives addresses, strobes and din; ROM/core return data.
interface ntt_bist_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ROM_AW = 11
);
  logic [2:0]        rom_sel;
  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              load_w;
  logic              load_data;
  logic              start;
  logic              start_intt;
  logic [DATA_W-1:0] din;
  logic              done;
  logic [DATA_W-1:0] dout;

  modport master (
    output rom_sel, rom_addr,
    output load_w, load_data,
    output start, start_intt, din,
    input  rom_data, done, dout
  );

  modport slave (
    input  rom_sel, rom_addr,
    input  load_w, load_data,
    input  start, start_intt, din,
    output rom_data, done, dout
  );
endinterface

// File: rtl/ntt_bist_ctrl.sv
// BIST sequencer for an NTT core: loads twiddles and data from ROM,
// runs NTT and/or INTT and checks the result stream against ROM.
module ntt_bist_ctrl #(
  parameter int DATA_W     = 64,
  parameter int RING_DEPTH = 10,
  parameter int PE_DEPTH   = 3,
  parameter int GAP        = 5,
  parameter int TIMEOUT    = 1 << 20,
  parameter int ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [1:0]            mode,
  ntt_bist_ctrl_if.master       bus,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [RING_DEPTH:0]   first_err_idx
);
  localparam int N  = 1 << RING_DEPTH;
  localparam int WN =
    ((1 << (RING_DEPTH - PE_DEPTH)) - 1 + PE_DEPTH)
    << PE_DEPTH;
  localparam int ROM_AW = $clog2((WN > N) ? WN : N);

  localparam logic [31:0] W_LAST = 32'(WN - 1);
  localparam logic [31:0] N_LAST = 32'(N - 1);
  localparam logic [31:0] G_LAST = 32'(GAP - 1);
  localparam logic [31:0] T_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LDW, WSTR, WISTR, PRM, GAP1, LDD,
    DSTR, GAP2, STRT, WAIT, CAP, GAP3, FIN
  } state_t;

  typedef enum logic [2:0] {
    SEL_W, SEL_WINV, SEL_PARAM, SEL_NDIN,
    SEL_NDOUT, SEL_IDIN, SEL_IDOUT
  } sel_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt;
  logic              phase, dual;
  sel_t              sel, din_sel, dout_sel;
  logic [ROM_AW-1:0] addr, nxt;
  logic              stream, to_hit, hit, bad;
  logic              lw, ld, sn, si;

  assign din_sel  = phase ? SEL_IDIN : SEL_NDIN;
  assign dout_sel = phase ? SEL_IDOUT : SEL_NDOUT;
  assign nxt      = ROM_AW'(cnt + 32'd1);

  // ROM is read one cycle ahead so the streams run without bubbles
  always_comb begin
    state_d = state_q;
    sel     = SEL_W;
    addr    = '0;
    stream  = 1'b0;
    to_hit  = 1'b0;
    lw      = 1'b0;
    ld      = 1'b0;
    sn      = 1'b0;
    si      = 1'b0;
    unique case (state_q)
      IDLE: if (go) state_d = LDW;
      LDW: begin
        lw      = 1'b1;
        state_d = WSTR;
      end
      WSTR: begin
        stream = 1'b1;
        if (cnt == W_LAST) begin
          sel     = SEL_WINV;
          state_d = WISTR;
        end else begin
          addr = nxt;
        end
      end
      WISTR: begin
        stream = 1'b1;
        if (cnt == W_LAST) begin
          sel     = SEL_PARAM;
          addr    = ROM_AW'(1);
          state_d = PRM;
        end else begin
          sel  = SEL_WINV;
          addr = nxt;
        end
      end
      PRM: begin
        stream = 1'b1;
        if (cnt == 32'd0) begin
          sel  = SEL_PARAM;
          addr = ROM_AW'(6);
        end else begin
          state_d = GAP1;
        end
      end
      GAP1: if (cnt == G_LAST) state_d = LDD;
      LDD: begin
        ld      = 1'b1;
        sel     = din_sel;
        state_d = DSTR;
      end
      DSTR: begin
        stream = 1'b1;
        if (cnt == N_LAST) begin
          state_d = GAP2;
        end else begin
          sel  = din_sel;
          addr = nxt;
        end
      end
      GAP2: if (cnt == G_LAST) state_d = STRT;
      STRT: begin
        sn      = !phase;
        si      = phase;
        state_d = WAIT;
      end
      WAIT: begin
        sel = dout_sel;
        if (bus.done) begin
          state_d = CAP;
        end else if (cnt == T_LAST) begin
          to_hit  = 1'b1;
          state_d = FIN;
        end
      end
      CAP: begin
        if (cnt == N_LAST) begin
          state_d = (dual && !phase) ? GAP3 : FIN;
        end else begin
          sel  = dout_sel;
          addr = nxt;
        end
      end
      GAP3: if (cnt == G_LAST) state_d = LDD;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rom_sel    = sel;
  assign bus.rom_addr   = addr;
  assign bus.load_w     = lw;
  assign bus.load_data  = ld;
  assign bus.start      = sn;
  assign bus.start_intt = si;
  assign bus.din        = stream ? bus.rom_data : '0;

  assign hit = (state_q == CAP) && (bus.dout != bus.rom_data);
  assign bad = hit || (err_cnt != '0) || to_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt           <= '0;
      phase         <= 1'b0;
      dual          <= 1'b0;
      busy          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || state_d != state_q) cnt <= '0;
      else cnt <= cnt + 32'd1;
      if (state_q == IDLE && go) begin
        phase         <= (mode == 2'b01);
        dual          <= mode[1];
        busy          <= 1'b1;
        pass          <= 1'b0;
        fail          <= 1'b0;
        timeout       <= 1'b0;
        err_cnt       <= '0;
        first_err_idx <= '0;
      end
      if (state_q == CAP && state_d == GAP3) phase <= 1'b1;
      if (hit) begin
        if (err_cnt == '0)
          first_err_idx <= {phase, cnt[RING_DEPTH-1:0]};
        if (!(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
      end
      if (to_hit) timeout <= 1'b1;
      // status settles as busy drops, on entry to FIN
      if (state_d == FIN) begin
        busy <= 1'b0;
        pass <= !bad;
        fail <= bad;
      end
    end
  end
endmodule

// File: tb/tb_ntt_bist_ctrl.sv
// Bench for ntt_bist_ctrl: ROM and NTT core models, a timeline
// reference model, vector table, random runs and corner sequences.
module tb_ntt_bist_ctrl;
  localparam int N    = 16;
  localparam int WN   = 16;
  localparam int GAP  = 5;
  localparam int EMAX = 3;

  logic       clk = 1'b0;
  logic       reset, go;
  logic [1:0] mode;
  logic       busy, pass, fail, timeout;
  logic [1:0] err_cnt;
  logic [4:0] first_err_idx;

  ntt_bist_ctrl_if #(.DATA_W(32), .ROM_AW(4)) bus ();

  ntt_bist_ctrl #(
    .DATA_W(32), .RING_DEPTH(4), .PE_DEPTH(1),
    .GAP(GAP), .TIMEOUT(100), .ERR_W(2)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .mode(mode),
    .bus(bus), .busy(busy), .pass(pass), .fail(fail),
    .timeout(timeout), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // synchronous ROM model
  logic [31:0] rom [7][16];
  always @(posedge clk)
    bus.rom_data <= (bus.rom_sel < 3'd7) ?
      rom[bus.rom_sel][bus.rom_addr] : 32'h0;

  // NTT core model: done lat cycles after start, then N words
  logic        core_en = 1'b1;
  int          core_lat = 3;
  logic [15:0] core_cn = '0, core_ci = '0, cmsk;
  logic        core_done = 1'b0, spur_done = 1'b0, cph;
  logic [31:0] core_dout = '0;
  assign bus.done = core_done | spur_done;
  assign bus.dout = core_dout;

  always begin
    @(posedge clk);
    if (core_en && (bus.start || bus.start_intt)) begin
      cph = bus.start_intt;
      repeat (core_lat - 1) @(posedge clk);
      #1 core_done = 1'b1;
      @(posedge clk);
      #1 core_done = 1'b0;
      for (int m = 0; m < N; m++) begin
        cmsk = cph ? core_ci : core_cn;
        core_dout = rom[cph ? 6 : 4][m] ^
                    (cmsk[m] ? 32'h8000_0000 : 32'h0);
        @(posedge clk);
        #1;
      end
      core_dout = '0;
    end
  end

  // event monitor
  int          cyc = 0;
  int          onehot_bad = 0;
  int          q_lw[$], q_ld[$], q_st[$], q_sp[$], q_dc[$];
  logic [31:0] q_dv[$];
  always @(posedge clk) begin
    if (int'(bus.load_w) + int'(bus.load_data) +
        int'(bus.start) + int'(bus.start_intt) > 1)
      onehot_bad++;
    if (bus.load_w) q_lw.push_back(cyc);
    if (bus.load_data) q_ld.push_back(cyc);
    if (bus.start || bus.start_intt) begin
      q_st.push_back(cyc);
      q_sp.push_back(int'(bus.start_intt));
    end
    if (bus.din != 32'h0) begin
      q_dv.push_back(bus.din);
      q_dc.push_back(cyc);
    end
    cyc++;
  end

  // reference: expected timeline and verdict from mode/masks
  task automatic check_run(input logic [1:0] md,
                           input logic [15:0] cn, ci,
                           input int lat, input int g);
    int          ph[$];
    logic [31:0] ev[$];
    int          ec[$];
    logic [15:0] msk;
    int t, ld, s, nerr, first, bd, nd;
    if (md == 2'b01) ph = '{1};
    else if (md[1]) ph = '{0, 1};
    else ph = '{0};
    t = g + 1;
    for (int k = 0; k < WN; k++) begin
      ev.push_back(rom[0][k]);
      ec.push_back(t + 1 + k);
    end
    for (int k = 0; k < WN; k++) begin
      ev.push_back(rom[1][k]);
      ec.push_back(t + 1 + WN + k);
    end
    ev.push_back(rom[2][1]);
    ec.push_back(t + 2 * WN + 1);
    ev.push_back(rom[2][6]);
    ec.push_back(t + 2 * WN + 2);
    chk("load_w count", q_lw.size(), 1);
    chk("load_w cycle", q_lw.size() > 0 ? q_lw[0] : -1, t);
    chk("load_data count", q_ld.size(), ph.size());
    chk("start count", q_st.size(), ph.size());
    ld = t + 2 * WN + 2 + GAP + 1;
    nerr = 0;
    first = 0;
    for (int i = 0; i < ph.size(); i++) begin
      for (int k = 0; k < N; k++) begin
        ev.push_back(rom[ph[i] != 0 ? 5 : 3][k]);
        ec.push_back(ld + 1 + k);
      end
      s = ld + N + GAP + 1;
      if (i < q_ld.size()) chk("load_data cycle", q_ld[i], ld);
      if (i < q_st.size()) begin
        chk("start cycle", q_st[i], s);
        chk("start kind", q_sp[i], ph[i]);
      end
      msk = (ph[i] != 0) ? ci : cn;
      for (int k = 0; k < N; k++)
        if (msk[k]) begin
          if (nerr == 0) first = ph[i] * N + k;
          nerr++;
        end
      ld = s + lat + N + GAP + 1;
    end
    chk("din word count", q_dv.size(), ev.size());
    bd = 0;
    nd = (q_dv.size() < ev.size()) ? q_dv.size() : ev.size();
    for (int i = 0; i < nd; i++)
      if (q_dv[i] !== ev[i] || q_dc[i] != ec[i]) bd++;
    chk("din stream", bd, 0);
    chk("err_cnt", err_cnt, (nerr > EMAX) ? EMAX : nerr);
    chk("first_err_idx", first_err_idx, first);
    chk("pass", pass, nerr == 0);
    chk("fail", fail, nerr != 0);
    chk("timeout", timeout, 0);
    chk("strobe overlap", onehot_bad, 0);
  endtask

  task automatic run_case(input logic [1:0] md,
                          input logic [15:0] cn, ci,
                          input int lat, input bit gwb);
    int g;
    bit ok;
    repeat (2) @(negedge clk);
    core_cn = cn;
    core_ci = ci;
    core_lat = lat;
    q_lw.delete(); q_ld.delete(); q_st.delete();
    q_sp.delete(); q_dc.delete(); q_dv.delete();
    onehot_bad = 0;
    mode = md;
    go = 1'b1;
    g = cyc;
    @(negedge clk);
    go = 1'b0;
    mode = 2'($urandom);
    if (gwb) begin
      repeat (8) @(negedge clk);
      go = 1'b1;
      spur_done = 1'b1;
      @(negedge clk);
      go = 1'b0;
      spur_done = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("run completes", ok, 1);
    check_run(md, cn, ci, lat, g);
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [15:0] cn, ci;
    int          lat;
    bit          gwb;
    int          e_err, e_first;
    bit          e_pass;
    int          e_ld, e_st, e_sti;
  } tv_t;

  tv_t tab[6];

  initial begin
    int  ns, nsi;
    bit  found;
    tab[0] = '{2'b00, 16'h0000, 16'h0000, 3, 1'b0,
               0, 0, 1'b1, 1, 1, 0};
    tab[1] = '{2'b10, 16'h0080, 16'h0204, 3, 1'b0,
               3, 7, 1'b0, 2, 1, 1};
    tab[2] = '{2'b01, 16'h0000, 16'h0000, 5, 1'b0,
               0, 0, 1'b1, 1, 0, 1};
    tab[3] = '{2'b00, 16'hffff, 16'h0000, 2, 1'b1,
               3, 0, 1'b0, 1, 1, 0};
    tab[4] = '{2'b11, 16'h0000, 16'h8000, 7, 1'b0,
               1, 31, 1'b0, 2, 1, 1};
    tab[5] = '{2'b01, 16'h0000, 16'h0009, 1, 1'b1,
               2, 16, 1'b0, 1, 0, 1};
    for (int s = 0; s < 7; s++)
      for (int a = 0; a < 16; a++)
        rom[s][a] = $urandom | 32'h1;

    reset = 1'b1;
    go = 1'b0;
    mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst pass/fail/timeout", {pass, fail, timeout}, 0);
    chk("rst err_cnt", err_cnt, 0);
    chk("rst first_err_idx", first_err_idx, 0);
    chk("rst strobes", {bus.load_w, bus.load_data,
                        bus.start, bus.start_intt}, 0);
    chk("rst din", bus.din, 0);
    chk("rst rom_sel", bus.rom_sel, 0);
    chk("rst rom_addr", bus.rom_addr, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_case(tab[i].md, tab[i].cn, tab[i].ci,
               tab[i].lat, tab[i].gwb);
      ns = 0;
      nsi = 0;
      foreach (q_sp[j]) if (q_sp[j] != 0) nsi++; else ns++;
      chk("tab err_cnt", err_cnt, tab[i].e_err);
      chk("tab first_err_idx", first_err_idx, tab[i].e_first);
      chk("tab pass", pass, tab[i].e_pass);
      chk("tab load_data", q_ld.size(), tab[i].e_ld);
      chk("tab start", ns, tab[i].e_st);
      chk("tab start_intt", nsi, tab[i].e_sti);
    end

    for (int i = 0; i < 6; i++)
      run_case(2'($urandom),
               16'($urandom & $urandom & $urandom),
               16'($urandom & $urandom & $urandom),
               $urandom_range(1, 30), 1'($urandom));

    // core never answers
    repeat (2) @(negedge clk);
    core_en = 1'b0;
    mode = 2'b00;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.start) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("timeout start seen", found, 1);
    repeat (100) @(negedge clk);
    chk("timeout not early", timeout, 0);
    chk("busy before timeout", busy, 1);
    @(negedge clk);
    chk("timeout flag", timeout, 1);
    chk("timeout fail", fail, 1);
    chk("timeout pass", pass, 0);
    chk("timeout busy", busy, 0);
    core_en = 1'b1;

    // reset in the middle of the data stream
    repeat (2) @(negedge clk);
    mode = 2'b00;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.load_data) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("load_data seen", found, 1);
    repeat (6) @(negedge clk);
    chk("din word 5", bus.din, rom[3][5]);
    reset = 1'b1;
    @(negedge clk);
    chk("mid reset strobes", {bus.load_w, bus.load_data,
                              bus.start, bus.start_intt}, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset din", bus.din, 0);
    chk("mid reset pass", pass, 0);
    reset = 1'b0;
    run_case(2'b00, 16'h0, 16'h0, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ntt_bist_ctrl.md
NTT_BIST_CTRL -- requirements
Module: ntt_bist_ctrl

Interface
REQ-001 SHALL take parameters: DATA_W, default 64, word width of din/dout/ROM data.
REQ-002 SHALL take RING_DEPTH, default 10, log2 ring size N.
REQ-003 SHALL take PE_DEPTH, default 3, log2 PE count; twiddle count WN=((2^(RING_DEPTH-PE_DEPTH))-1+PE_DEPTH)<<PE_DEPTH.
REQ-004 SHALL take GAP, default 5, idle cycles between phases.
REQ-005 SHALL take TIMEOUT, default 2^20, max cycles waiting for done.
REQ-006 SHALL take ERR_W, default 16, err_cnt width; ROM_AW = clog2(max(WN,N)).
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk input 1, reset input 1.
REQ-008 go  input 1  single-cycle run request.
REQ-009 mode  input 2  00 NTT only, 01 INTT only, 10 NTT then INTT, 11 treated as 10.
REQ-010 rom_sel  output 3  0 W, 1 WINV, 2 PARAM, 3 NTT_DIN, 4 NTT_DOUT, 5 INTT_DIN, 6 INTT_DOUT.
REQ-011 rom_addr  output ROM_AW  word address; rom_data input DATA_W, valid one cycle after rom_sel/rom_addr.
REQ-012 load_w, load_data, start, start_intt  outputs 1  single-cycle strobes to the NTT core.
REQ-013 din  output DATA_W  stream to core; done input 1; dout input DATA_W  core result stream.
REQ-014 busy, pass, fail, timeout  outputs 1; err_cnt output ERR_W; first_err_idx output RING_DEPTH+1 (MSB = 1 for INTT phase).

Function
REQ-015 States SHALL be: IDLE, LDW, WSTR, WISTR, PRM, GAP1, LDD, DSTR, GAP2, STRT, WAIT, CAP, GAP3, FIN.
REQ-016 IDLE: go=1 SHALL clear pass/fail/timeout/err_cnt/first_err_idx, set busy, enter LDW.
REQ-017 LDW SHALL assert load_w one cycle; din word k of WSTR SHALL appear k+1 cycles after the load_w cycle.
REQ-018 WSTR SHALL drive W[0..WN-1], WISTR WINV[0..WN-1], PRM PARAM[1] then PARAM[6], one word per cycle, no gaps.
REQ-019 ROM reads SHALL be issued one cycle ahead so every din word is back-to-back; din SHALL be 0 outside streaming states.
REQ-020 GAP1/GAP2/GAP3 SHALL last exactly GAP cycles each.
REQ-021 LDD SHALL pulse load_data one cycle; DSTR SHALL drive N words from NTT_DIN (NTT phase) or INTT_DIN (INTT phase), starting the next cycle.
REQ-022 STRT SHALL pulse start (NTT phase) or start_intt (INTT phase) for one cycle, then WAIT.
REQ-023 WAIT SHALL count cycles; done=1 SHALL move to CAP; count reaching TIMEOUT SHALL set timeout and fail and go to FIN.
REQ-024 CAP SHALL sample dout word m in the (m+1)-th cycle after the cycle done was sampled high, m=0..N-1, comparing against expected ROM word m.
REQ-025 Each mismatch SHALL increment err_cnt, saturating at 2^ERR_W-1; the first mismatch of the run SHALL latch first_err_idx.
REQ-026 After CAP: mode 10 and NTT phase complete -> GAP3 -> LDD (INTT phase, no twiddle reload); else -> FIN.
REQ-027 mode 01 SHALL skip the NTT phase entirely but still load twiddles.
REQ-028 FIN SHALL clear busy, set pass=(err_cnt==0 and !timeout), fail=!pass, return to IDLE; status held until next go.
REQ-029 go while busy SHALL be ignored; done outside WAIT SHALL be ignored.
REQ-030 At most one of load_w/load_data/start/start_intt SHALL be high in any cycle.

Reset
REQ-031 reset=1 SHALL, on the next clk edge, force IDLE from any state, including mid-stream or mid-capture.
REQ-032 Reset values: all strobes 0, din 0, rom_sel 0, rom_addr 0, busy 0, pass 0, fail 0, timeout 0, err_cnt 0, first_err_idx 0.

Verification (RING_DEPTH=4, PE_DEPTH=1 -> N=16, WN=16; GAP=5)
REQ-033 mode 00, model core returns expected data 3 cycles after start -> load_w at T, din W[0] at T+1, PARAM[6] at T+34; pass=1, err_cnt=0.
REQ-034 mode 10, model corrupts NTT word 7 and INTT words 2,9 -> err_cnt=3, first_err_idx=7, fail=1, exactly one load_w and two load_data.
REQ-035 mode 01 -> start never asserted, start_intt once, INTT_DIN streamed; pass=1.
REQ-036 done never asserted, TIMEOUT=100 -> timeout=1, fail=1, busy=0 within 101 cycles of start.
REQ-037 reset asserted during DSTR word 5 -> next cycle all strobes 0, busy 0; subsequent go runs cleanly to pass=1.
REQ-038 ERR_W=2, all 16 words wrong -> err_cnt=3 (saturated), first_err_idx=0; go pulsed while busy has no effect.
